// File: rtl/clash_pkg.sv
// rtl/clash_pkg.sv - shared target codes, tower states and frame-count constants
package clash_pkg;

  typedef enum logic [2:0] {
    TGT_NONE  = 3'd0,
    TGT_RIGHT = 3'd1,
    TGT_LEFT  = 3'd2,
    TGT_KING  = 3'd3
  } target_code_e;

  localparam int FLASH_FRAMES = 8;
  localparam int REGEN_PERIOD = 64;

  localparam logic [1:0] ST_ALIVE     = 2'd0;
  localparam logic [1:0] ST_HIT       = 2'd1;
  localparam logic [1:0] ST_DESTROYED = 2'd2;

endpackage

// File: rtl/tower_hp_cell.sv
// rtl/tower_hp_cell.sv - one tower: saturating HP register, ALIVE/HIT/DESTROYED FSM, flash counter
// Optional regeneration counter built only when TOWER_REGEN_EN is defined.
module tower_hp_cell
  import clash_pkg::*;
#(
  parameter int HP_W    = 6,
  parameter int INIT_HP = 40,
  parameter int DMG_W   = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             tick_i,
  input  logic [DMG_W-1:0] damage_i,
  output logic [HP_W-1:0]  hp_o,
  output logic             flash_o,
  output logic             destroyed_o
);

  localparam int CW = (HP_W > DMG_W) ? HP_W : DMG_W;
  localparam int FW = $clog2(FLASH_FRAMES);

  logic [1:0]      state_q, state_d;
  logic [HP_W-1:0] hp_q, hp_d;
  logic [FW-1:0]   flash_q, flash_d;
  logic [CW-1:0]   hp_ext, dmg_ext, new_hp;
  logic            hit;

`ifdef TOWER_REGEN_EN
  localparam int RW = $clog2(REGEN_PERIOD);
  logic [RW-1:0] regen_q, regen_d;
`endif

  assign hp_ext  = CW'(hp_q);
  assign dmg_ext = CW'(damage_i);
  assign new_hp  = (hp_ext >= dmg_ext) ? (hp_ext - dmg_ext) : '0;
  assign hit     = (damage_i != '0) && (state_q != ST_DESTROYED);

  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    flash_d = flash_q;
`ifdef TOWER_REGEN_EN
    regen_d = regen_q;
`endif
    if (tick_i && (state_q != ST_DESTROYED)) begin
      if (hit) begin
`ifdef TOWER_REGEN_EN
        regen_d = '0;
`endif
        flash_d = '0;
        if (new_hp == '0) begin
          state_d = ST_DESTROYED;
          hp_d    = '0;
        end else begin
          state_d = ST_HIT;
          hp_d    = HP_W'(new_hp);
        end
      end else begin
        // flash_q counts hitless ticks since the last hit; the 8th one ends the flash
        if (state_q == ST_HIT) begin
          if (flash_q == FW'(FLASH_FRAMES - 1)) begin
            state_d = ST_ALIVE;
            flash_d = '0;
          end else begin
            flash_d = flash_q + 1'b1;
          end
        end
`ifdef TOWER_REGEN_EN
        if (regen_q == RW'(REGEN_PERIOD - 1)) begin
          regen_d = '0;
          if ((state_q == ST_ALIVE) && (hp_q < HP_W'(INIT_HP))) begin
            hp_d = hp_q + 1'b1;
          end
        end else begin
          regen_d = regen_q + 1'b1;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_ALIVE;
      hp_q    <= HP_W'(INIT_HP);
      flash_q <= '0;
`ifdef TOWER_REGEN_EN
      regen_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      flash_q <= flash_d;
`ifdef TOWER_REGEN_EN
      regen_q <= regen_d;
`endif
    end
  end

  assign hp_o        = hp_q;
  assign flash_o     = (state_q == ST_HIT);
  assign destroyed_o = (state_q == ST_DESTROYED);

endmodule

// File: rtl/tower_damage.sv
// rtl/tower_damage.sv - vsync frame tick, per-tower hit counting, king shield, three tower cells
// Tower regeneration is enabled by defining TOWER_REGEN_EN.
module tower_damage
  import clash_pkg::*;
#(
  parameter int NUM_UNITS = 4,
  parameter int SIDE_HP   = 40,
  parameter int KING_HP   = 60,
  parameter int HIT_DMG   = 3
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  input  logic                   vsync,
  input  logic [NUM_UNITS*3-1:0] attackindex,
  output logic [5:0]             hpr,
  output logic [5:0]             hpl,
  output logic [6:0]             hpk,
  output logic                   towerrd,
  output logic                   towerld,
  output logic                   kingd,
  output logic [2:0]             hit_flash,
  output logic                   game_over
);

  localparam int CNT_W = $clog2(NUM_UNITS + 1);
  localparam int DMG_W = $clog2(NUM_UNITS * HIT_DMG + 1);
  localparam int CW    = (DMG_W > 6) ? DMG_W : 6;

  logic [1:0]       vs_q;
  logic             frame_tick;
  logic [CNT_W-1:0] hits_r, hits_l, hits_k;
  logic [DMG_W-1:0] dmg_r, dmg_l, dmg_k_raw, dmg_k;
  logic             shield_open;
  logic             flash_r, flash_l, flash_k;

  always_ff @(posedge vga_clk) begin
    if (reset) vs_q <= '0;
    else       vs_q <= {vs_q[0], vsync};
  end

  assign frame_tick = vs_q[0] & ~vs_q[1];

  always_comb begin
    hits_r = '0;
    hits_l = '0;
    hits_k = '0;
    for (int u = 0; u < NUM_UNITS; u++) begin
      case (attackindex[3*u +: 3])
        TGT_RIGHT: hits_r = hits_r + 1'b1;
        TGT_LEFT:  hits_l = hits_l + 1'b1;
        TGT_KING:  hits_k = hits_k + 1'b1;
        default:   ;
      endcase
    end
  end

  assign dmg_r     = DMG_W'(hits_r) * DMG_W'(HIT_DMG);
  assign dmg_l     = DMG_W'(hits_l) * DMG_W'(HIT_DMG);
  assign dmg_k_raw = DMG_W'(hits_k) * DMG_W'(HIT_DMG);

  // A side tower falling in this very frame already opens the king to this frame's hits
  assign shield_open = towerrd || towerld
                    || ((dmg_r != '0) && (CW'(hpr) <= CW'(dmg_r)))
                    || ((dmg_l != '0) && (CW'(hpl) <= CW'(dmg_l)));
  assign dmg_k = shield_open ? dmg_k_raw : '0;

  tower_hp_cell #(.HP_W(6), .INIT_HP(SIDE_HP), .DMG_W(DMG_W)) u_right (
    .clk_i(vga_clk), .reset_i(reset), .tick_i(frame_tick), .damage_i(dmg_r),
    .hp_o(hpr), .flash_o(flash_r), .destroyed_o(towerrd)
  );

  tower_hp_cell #(.HP_W(6), .INIT_HP(SIDE_HP), .DMG_W(DMG_W)) u_left (
    .clk_i(vga_clk), .reset_i(reset), .tick_i(frame_tick), .damage_i(dmg_l),
    .hp_o(hpl), .flash_o(flash_l), .destroyed_o(towerld)
  );

  tower_hp_cell #(.HP_W(7), .INIT_HP(KING_HP), .DMG_W(DMG_W)) u_king (
    .clk_i(vga_clk), .reset_i(reset), .tick_i(frame_tick), .damage_i(dmg_k),
    .hp_o(hpk), .flash_o(flash_k), .destroyed_o(kingd)
  );

  assign hit_flash = {flash_k, flash_l, flash_r};
  assign game_over = kingd;

endmodule

// File: doc/tower_damage.md
TOWER_DAMAGE -- requirements
Module: tower_damage

Interface
Parameters (name, default, meaning):
REQ-001 NUM_UNITS, 4, number of attacking-unit attack-index inputs.
REQ-002 SIDE_HP, 40, initial HP of right and left side towers.
REQ-003 KING_HP, 60, initial HP of king tower.
REQ-004 HIT_DMG, 3, HP removed per accepted hit.
Ports (name, direction, width, meaning):
REQ-005 vga_clk  in  1  sole clock.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 vsync  in  1  frame strobe, sampled as data in vga_clk domain.
REQ-008 attackindex  in  NUM_UNITS x 3  per-unit target code, held one frame: 0 none, 1 right, 2 left, 3 king, 4-7 ignored.
REQ-009 hpr, hpl, hpk  out  6/6/7  current right/left/king HP.
REQ-010 towerrd, towerld, kingd  out  1 each  tower destroyed flags.
REQ-011 hit_flash  out  3  per-tower {king,left,right} flash, high 8 frames after a hit.
REQ-012 game_over  out  1  high while kingd high.

Function
REQ-013 vsync registered twice, edge-detected; frame_tick is a one-vga_clk pulse on each rising vsync.
REQ-014 All attackindex sampling and HP updates occur only on the vga_clk edge where frame_tick is high; other cycles hold state.
REQ-015 Per tower, hits = count of units whose code matches that tower in the sampled frame (0..NUM_UNITS).
REQ-016 Damage = hits x HIT_DMG, computed at width sufficient for NUM_UNITS x HIT_DMG without overflow.
REQ-017 New HP = HP - damage if HP >= damage, else 0 (saturating, never wraps).
REQ-018 Per-tower FSM: ALIVE -> HIT (damage>0 and new HP>0) -> ALIVE after 8 frame_ticks with no further hit; ALIVE/HIT -> DESTROYED when new HP = 0.
REQ-019 A hit in HIT restarts the 8-frame flash counter.
REQ-020 DESTROYED absorbing until reset; hits to destroyed tower ignored; HP stays 0.
REQ-021 towerrd/towerld/kingd high iff corresponding FSM is DESTROYED, asserted same cycle HP becomes 0.
REQ-022 King tower ignores code 3 while both side towers alive (king shielded); accepts once either side tower DESTROYED, including the frame in which that side tower is destroyed.
REQ-023 hit_flash bit high iff that tower FSM is HIT.
REQ-024 Codes 4-7 and 0 contribute no damage.
REQ-025 Simultaneous hits on multiple towers in one frame are all applied in that frame.

Reset
REQ-026 On reset: hpr=hpl=SIDE_HP, hpk=KING_HP, all FSMs ALIVE, flash counters 0, destroyed flags 0, hit_flash 0, game_over 0, vsync pipeline 0.
REQ-027 Reset coinciding with frame_tick wins; that frame's hits discarded.

Configuration
REQ-028 Macro TOWER_REGEN_EN: defined -> each ALIVE (not HIT, not DESTROYED) tower gains 1 HP every 64 frame_ticks without hits, capped at its initial HP; undefined -> no regeneration logic, HP never increases except by reset.
REQ-029 With TOWER_REGEN_EN, any hit clears that tower's regen frame counter.

Structure
REQ-030 Shared package clash_pkg holds target-code enum (NONE, RIGHT, LEFT, KING), flash length 8, regen period 64.
REQ-031 One sub-module tower_hp_cell (HP register, FSM, flash and regen counters), instantiated three times; tower_damage holds vsync edge detect, hit counting, king shield.

Verification
REQ-032 Reset, one unit code 1 for 1 frame -> hpr 40->37, hit_flash[0] high exactly 8 frames.
REQ-033 Four units code 2 for 4 frames -> hpl 40,28,16,4,0; towerld and DESTROYED on 4th frame_tick; later hits no effect.
REQ-034 Code 3 with both side towers alive -> hpk stays 60; after towerrd, one code-3 hit -> hpk 57.
REQ-035 King driven to 0 -> kingd and game_over high same cycle; reset -> all HP restored, flags low.
REQ-036 TOWER_REGEN_EN defined, hpr=37, 64 hitless frames -> hpr 38; at 40 no increase; undefined build -> hpr stays 37.
REQ-037 attackindex toggled between vsync edges -> only value present at frame_tick counted; codes 4-7 -> no HP change.
